// File: rtl/sys_bus_decoder.sv
// System bus address decoder: routes one outstanding request to one of SN
// subordinate register blocks and returns its ack/rdata/err upstream.
module sys_bus_decoder #(
  parameter int unsigned   DW = 32,
  parameter int unsigned   AW = 32,
  parameter int unsigned   SN = 8,
  parameter int unsigned   SL = 20,
  parameter logic [SN-1:0] EN = {SN{1'b1}}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [AW-1:0]    s_addr,
  input  logic [DW-1:0]    s_wdata,
  input  logic             s_wen,
  input  logic             s_ren,
  output logic [DW-1:0]    s_rdata,
  output logic             s_ack,
  output logic             s_err,
  output logic [AW-1:0]    m_addr,
  output logic [DW-1:0]    m_wdata,
  output logic [SN-1:0]    m_wen,
  output logic [SN-1:0]    m_ren,
  input  logic [SN*DW-1:0] m_rdata,
  input  logic [SN-1:0]    m_ack,
  input  logic [SN-1:0]    m_err,
  output logic             busy,
  output logic             drop
);

  localparam int unsigned   IW      = $clog2(SN);
  localparam logic [AW-1:0] LO_MASK = AW'((64'(1) << SL) - 64'(1));

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t          state;
  logic [IW-1:0]   sel;
  logic            local_err;

  logic            req_c;
  logic            accept_c;
  logic [IW-1:0]   idx_c;
  logic [DW-1:0]   sel_rdata_c;

  // Requests arriving while busy or during the s_ack cycle are discarded.
  assign req_c       = s_wen | s_ren;
  assign accept_c    = req_c & (state == IDLE) & ~s_ack;
  assign idx_c       = s_addr[SL +: IW];
  assign sel_rdata_c = m_rdata[sel*DW +: DW];
  assign busy        = (state == WAIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      sel       <= '0;
      local_err <= 1'b0;
      s_rdata   <= '0;
      s_ack     <= 1'b0;
      s_err     <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_wen     <= '0;
      m_ren     <= '0;
      drop      <= 1'b0;
    end else begin
      m_wen <= '0;
      m_ren <= '0;
      s_ack <= 1'b0;
      s_err <= 1'b0;
      drop  <= req_c & ~accept_c;
      case (state)
        IDLE: begin
          if (accept_c) begin
            state   <= WAIT;
            sel     <= idx_c;
            m_addr  <= s_addr & LO_MASK;
            m_wdata <= s_wdata;
            if (EN[idx_c]) begin
              local_err <= 1'b0;
              // Write wins when both strobes are raised together.
              if (s_wen) m_wen[idx_c] <= 1'b1;
              else       m_ren[idx_c] <= 1'b1;
            end else begin
              local_err <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (local_err) begin
            state     <= IDLE;
            local_err <= 1'b0;
            s_ack     <= 1'b1;
            s_err     <= 1'b1;
            s_rdata   <= '0;
          end else if (m_ack[sel]) begin
            state   <= IDLE;
            s_ack   <= 1'b1;
            s_err   <= m_err[sel];
            s_rdata <= sel_rdata_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_bus_decoder.sv
// Scoreboard bench for sys_bus_decoder: directed stimulus pushes expected
// subordinate strobes, upstream responses and drop pulses; a monitor checks them.
module tb_sys_bus_decoder;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SN = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic             s_wen, s_ren;
  logic [DW-1:0]    s_rdata;
  logic             s_ack, s_err;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic [SN-1:0]    m_wen, m_ren;
  logic [SN*DW-1:0] m_rdata;
  logic [SN-1:0]    m_ack, m_err;
  logic             busy, drop;

  sys_bus_decoder #(.DW(DW), .AW(AW), .SN(SN), .SL(20), .EN(8'h7F)) dut (
    .clk(clk), .rstn(rstn),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wen(s_wen), .s_ren(s_ren),
    .s_rdata(s_rdata), .s_ack(s_ack), .s_err(s_err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen), .m_ren(m_ren),
    .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
    .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  wen;
    logic [7:0]  ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } mexp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
    int          cyc;
  } sexp_t;

  mexp_t mq[$];
  sexp_t sq[$];
  int    dq[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented output against the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (m_wen != '0 || m_ren != '0) begin
        if (mq.size() == 0) chk("unexpected_m_strobe", {m_wen, m_ren}, 64'h0);
        else begin
          mexp_t e;
          e = mq.pop_front();
          chk("m_wen", m_wen, e.wen);
          chk("m_ren", m_ren, e.ren);
          chk("m_addr", m_addr, e.addr);
          chk("m_wdata", m_wdata, e.wdata);
          chk("m_strobe_cycle", cyc, e.cyc);
        end
      end
      if (s_ack) begin
        if (sq.size() == 0) chk("unexpected_s_ack", s_ack, 64'h0);
        else begin
          sexp_t e;
          e = sq.pop_front();
          chk("s_err", s_err, e.err);
          if (e.chk_rdata) chk("s_rdata", s_rdata, e.rdata);
          chk("s_ack_cycle", cyc, e.cyc);
        end
      end else if (s_err) begin
        chk("s_err_without_ack", s_err, 64'h0);
      end
      if (drop) begin
        if (dq.size() == 0) chk("unexpected_drop", drop, 64'h0);
        else chk("drop_cycle", cyc, dq.pop_front());
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && (mq.size() != 0 || sq.size() != 0 || dq.size() != 0); i++) step();
    chk("drain_pending", mq.size() + sq.size() + dq.size(), 64'h0);
  endtask

  task automatic set_rdata(input int port, input logic [31:0] v);
    m_rdata[port*DW +: DW] = v;
  endtask

  initial begin
    int c0;
    rstn = 1'b0; s_addr = '0; s_wdata = '0; s_wen = 1'b0; s_ren = 1'b0;
    m_rdata = '0; m_ack = '0; m_err = '0;
    step(); step();
    chk("rst_s_ack", s_ack, 0);   chk("rst_s_err", s_err, 0);
    chk("rst_busy", busy, 0);     chk("rst_drop", drop, 0);
    chk("rst_m_wen", m_wen, 0);   chk("rst_m_ren", m_ren, 0);
    chk("rst_s_rdata", s_rdata, 0); chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    rstn = 1'b1;
    step();

    // Write to port 3, ack two cycles after the strobe.
    c0 = cyc;
    s_wen = 1'b1; s_addr = 32'h0030_0004; s_wdata = 32'hDEAD_BEEF;
    mq.push_back('{8'h08, 8'h00, 32'h4, 32'hDEAD_BEEF, c0 + 1});
    sq.push_back('{32'h0, 1'b0, 1'b0, c0 + 4});
    step(); s_wen = 1'b0;
    chk("t1_busy", busy, 1);
    step();
    step(); m_ack = 8'h08;
    step(); m_ack = '0;
    drain();
    chk("t1_idle", busy, 0);

    // Read port 5 with combinational ack; a strobe in the s_ack cycle is dropped.
    set_rdata(5, 32'h1234_5678);
    c0 = cyc;
    s_ren = 1'b1; s_addr = 32'h0050_0010; s_wdata = 32'h0;
    mq.push_back('{8'h00, 8'h20, 32'h10, 32'h0, c0 + 1});
    sq.push_back('{32'h1234_5678, 1'b0, 1'b1, c0 + 2});
    step(); s_ren = 1'b0; m_ack = 8'h20;
    step(); m_ack = '0; s_ren = 1'b1; s_addr = 32'h0010_0000;
    dq.push_back(c0 + 3);
    step(); s_ren = 1'b0;
    drain();
    chk("t2_rdata_hold", s_rdata, 32'h1234_5678);
    chk("t2_m_addr_hold", m_addr, 32'h10);

    // Unmapped window 7 answers locally with an error.
    set_rdata(7, 32'hFFFF_FFFF);
    c0 = cyc;
    s_ren = 1'b1; s_addr = 32'h0070_0000;
    sq.push_back('{32'h0, 1'b1, 1'b1, c0 + 2});
    step(); s_ren = 1'b0;
    chk("t3_busy", busy, 1);
    drain();

    // Port 2 pending; stray port-4 ack and a new write while busy are ignored.
    set_rdata(2, 32'hCAFE_0002);
    set_rdata(4, 32'h0BAD_0004);
    c0 = cyc;
    s_ren = 1'b1; s_addr = 32'h0020_0008;
    mq.push_back('{8'h00, 8'h04, 32'h8, 32'h0, c0 + 1});
    sq.push_back('{32'hCAFE_0002, 1'b1, 1'b1, c0 + 6});
    step(); s_ren = 1'b0;
    step(); m_ack = 8'h10; m_err = 8'h10;
    step(); m_ack = '0; m_err = '0;
    s_wen = 1'b1; s_addr = 32'h0010_0000; s_wdata = 32'h1111_1111;
    dq.push_back(c0 + 4);
    step(); s_wen = 1'b0;
    chk("t4_m_addr_kept", m_addr, 32'h8);
    chk("t4_m_wdata_kept", m_wdata, 32'h0);
    chk("t4_busy_kept", busy, 1);
    step(); m_ack = 8'h04; m_err = 8'h04;
    step(); m_ack = '0; m_err = '0;
    drain();

    // Simultaneous write and read strobes to port 1: write wins.
    set_rdata(1, 32'h0000_0101);
    c0 = cyc;
    s_wen = 1'b1; s_ren = 1'b1; s_addr = 32'h0010_0020; s_wdata = 32'hA5A5_A5A5;
    mq.push_back('{8'h02, 8'h00, 32'h20, 32'hA5A5_A5A5, c0 + 1});
    sq.push_back('{32'h0, 1'b0, 1'b0, c0 + 2});
    step(); s_wen = 1'b0; s_ren = 1'b0; m_ack = 8'h02;
    step(); m_ack = '0;
    drain();

    // Reset in the middle of a read of port 3; late ack must not surface.
    s_ren = 1'b1; s_addr = 32'h0030_0000;
    step(); s_ren = 1'b0; rstn = 1'b0;
    #2;
    chk("t6_rst_busy", busy, 0);     chk("t6_rst_m_ren", m_ren, 0);
    chk("t6_rst_s_rdata", s_rdata, 0); chk("t6_rst_m_addr", m_addr, 0);
    chk("t6_rst_m_wdata", m_wdata, 0); chk("t6_rst_s_ack", s_ack, 0);
    step();
    rstn = 1'b1;
    step(); m_ack = 8'h08;
    step(); m_ack = '0;
    repeat (4) step();
    chk("t6_busy_after", busy, 0);
    chk("t6_pending", mq.size() + sq.size() + dq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
